// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              m0_enable_i;
  logic              m0_write_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [LINE_W-1:0] m0_data_i;
  logic [LINE_W-1:0] m0_data_o;
  logic              m0_ack_o;

  logic              m1_enable_i;
  logic              m1_write_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [LINE_W-1:0] m1_data_i;
  logic [LINE_W-1:0] m1_data_o;
  logic              m1_ack_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  // Arbiter view
  modport slave (
    input  m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    output m0_data_o, m0_ack_o,
    input  m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    output m1_data_o, m1_ack_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  // Cache controllers plus memory model view
  modport master (
    output m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
    input  m0_data_o, m0_ack_o,
    output m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
    input  m1_data_o, m1_ack_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master line arbiter for the memory port (MEM_ARB_RR_EN selects round-robin ties)
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              grant0;
  logic              any_req;
  logic              busy;

  assign any_req = bus.m0_enable_i | bus.m1_enable_i;

`ifdef MEM_ARB_RR_EN
  // last_q holds the port granted most recently; on a tie the other port wins
  logic last_q, last_d;
  assign grant0 = bus.m0_enable_i & (~bus.m1_enable_i | last_q);

  // Last-grant pointer, starts at 1 so port 0 wins the first tie
  always_ff @(posedge clk_i) begin
    if (!rst_i) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  // Instruction cache always wins a tie
  assign grant0 = bus.m0_enable_i;
`endif

  // Next state: grant in IDLE, then hold the latched command until the memory acks
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = grant0 ? BUSY0 : BUSY1;
          wr_d    = grant0 ? bus.m0_write_i : bus.m1_write_i;
          addr_d  = grant0 ? bus.m0_addr_i  : bus.m1_addr_i;
          data_d  = grant0 ? bus.m0_data_i  : bus.m1_data_i;
`ifdef MEM_ARB_RR_EN
          last_d  = ~grant0;
`endif
        end
      end
      BUSY0, BUSY1: begin
        if (bus.mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched command registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Memory side is driven only while a grant is held so IDLE presents a clean zero bus
  assign busy             = (state_q == BUSY0) || (state_q == BUSY1);
  assign bus.mem_enable_o = busy;
  assign bus.mem_write_o  = busy & wr_q;
  assign bus.mem_addr_o   = busy ? addr_q : '0;
  assign bus.mem_data_o   = busy ? data_q : '0;

  // Ack goes only to the granted port; reset low suppresses it even mid-transaction
  assign bus.m0_ack_o  = rst_i & bus.mem_ack_i & (state_q == BUSY0);
  assign bus.m1_ack_o  = rst_i & bus.mem_ack_i & (state_q == BUSY1);
  assign bus.m0_data_o = rst_i ? bus.mem_data_i : '0;
  assign bus.m1_data_o = rst_i ? bus.mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  typedef struct {
    logic         port;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    logic         b2b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_ack_cyc = 0;
  int   lat = 3;
  logic model_on = 1'b1;
  exp_t exp_q[$];

  localparam logic [255:0] D11 = {32{8'h11}};
  localparam logic [255:0] D22 = {32{8'h22}};
  localparam logic [255:0] DA5 = {32{8'hA5}};
  localparam logic [255:0] DWB = {8{32'hDEADBEEF}};

  mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [255:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: return D11;
      32'h200: return D22;
      32'h400: return DA5;
      default: return {32{8'h5A}};
    endcase
  endfunction

  task automatic push(input logic p, input logic wr, input logic [31:0] a,
                      input logic [255:0] wd, input logic [255:0] rd, input logic b2b);
    exp_t e;
    e.port = p; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd; e.b2b = b2b;
    exp_q.push_back(e);
  endtask

  task automatic req(input int p, input logic wr, input logic [31:0] a, input logic [255:0] d);
    if (p == 0) begin
      bus.m0_write_i = wr; bus.m0_addr_i = a; bus.m0_data_i = d; bus.m0_enable_i = 1'b1;
    end else begin
      bus.m1_write_i = wr; bus.m1_addr_i = a; bus.m1_data_i = d; bus.m1_enable_i = 1'b1;
    end
  endtask

  task automatic wait_ack(input int p);
    int n = 0;
    while (n < 300) begin
      @(negedge clk);
      if ((p == 0) ? bus.m0_ack_o : bus.m1_ack_o) break;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL ack_timeout port%0d: waited %0d cycles, required ack within 300", p, n);
    end
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks lat cycles after the request appears
  int cnt = 0;
  initial begin
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (model_on) begin
        if (!rst) begin
          bus.mem_ack_i = 1'b0; cnt = 0;
        end else if (bus.mem_ack_i) begin
          bus.mem_ack_i = 1'b0; cnt = 0;
        end else if (bus.mem_enable_o) begin
          cnt++;
          if (cnt >= lat) begin
            bus.mem_ack_i  = 1'b1;
            bus.mem_data_i = mem_rd(bus.mem_addr_o);
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  // Monitor: compares memory commands and acks against the expected queue
  logic en_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.mem_enable_o) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_req: got request addr %0h, required none", bus.mem_addr_o);
          end else begin
            e = exp_q[0];
            if (!en_prev) begin
              chk("start_write", bus.mem_write_o, e.wr);
              if (e.wr) chk("start_wdata", bus.mem_data_o, e.wdata);
              if (e.b2b) chk("idle_gap", cyc - last_ack_cyc, 2);
            end
            chk("hold_addr", bus.mem_addr_o, e.addr);
            chk("hold_write", bus.mem_write_o, e.wr);
          end
        end
        if (bus.m0_ack_o || bus.m1_ack_o) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ack: got m0_ack=%0b m1_ack=%0b, required none", bus.m0_ack_o, bus.m1_ack_o);
          end else begin
            e = exp_q.pop_front();
            chk("ack_port0", bus.m0_ack_o, !e.port);
            chk("ack_port1", bus.m1_ack_o, e.port);
            if (!e.wr) chk("rdata", e.port ? bus.m1_data_o : bus.m0_data_o, e.rdata);
            last_ack_cyc = cyc;
          end
        end
      end
      en_prev = bus.mem_enable_o;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_enable"}, bus.mem_enable_o, 0);
    chk({tag, "_mem_write"}, bus.mem_write_o, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr_o, 0);
    chk({tag, "_mem_data"}, bus.mem_data_o, 0);
    chk({tag, "_m0_ack"}, bus.m0_ack_o, 0);
    chk({tag, "_m1_ack"}, bus.m1_ack_o, 0);
    chk({tag, "_m0_data"}, bus.m0_data_o, 0);
    chk({tag, "_m1_data"}, bus.m1_data_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m0_enable_i = 0; bus.m0_write_i = 0; bus.m0_addr_i = 0; bus.m0_data_i = 0;
    bus.m1_enable_i = 0; bus.m1_write_i = 0; bus.m1_addr_i = 0; bus.m1_data_i = 0;

    // Reset held with both ports requesting
    req(0, 1'b0, 32'h100, '0);
    req(1, 1'b0, 32'h200, '0);
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("rst");
    end
    push(1'b0, 1'b0, 32'h100, '0, D11, 1'b0);
    push(1'b1, 1'b0, 32'h200, '0, D22, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_enable_low", bus.mem_enable_o, 0);
    @(negedge clk);
    chk("rel_enable_high", bus.mem_enable_o, 1);
    fork
      begin wait_ack(0); bus.m0_enable_i = 0; end
      begin wait_ack(1); bus.m1_enable_i = 0; end
    join

    // Port 1 read alone, slow memory
    lat = 10;
    push(1'b1, 1'b0, 32'h400, '0, DA5, 1'b0);
    req(1, 1'b0, 32'h400, '0);
    wait_ack(1);
    bus.m1_enable_i = 0;

    // Port 1 writeback then refill with enable held
    lat = 3;
    push(1'b1, 1'b1, 32'hC00, DWB, '0, 1'b0);
    push(1'b1, 1'b0, 32'h400, '0, DA5, 1'b1);
    req(1, 1'b1, 32'hC00, DWB);
    wait_ack(1);
    bus.m1_write_i = 1'b0; bus.m1_addr_i = 32'h400;
    wait_ack(1);
    bus.m1_enable_i = 0;

    // Tie A: port 0 first in both modes
    repeat (2) @(posedge clk); #1;
    push(1'b0, 1'b0, 32'h100, '0, D11, 1'b0);
    push(1'b1, 1'b0, 32'h200, '0, D22, 1'b1);
    req(0, 1'b0, 32'h100, '0);
    req(1, 1'b0, 32'h200, '0);
    fork
      begin wait_ack(0); bus.m0_enable_i = 0; end
      begin wait_ack(1); bus.m1_enable_i = 0; end
    join

    // Port 0 drops enable and changes address mid-transaction
    lat = 6;
    push(1'b0, 1'b0, 32'h100, '0, D11, 1'b0);
    req(0, 1'b0, 32'h100, '0);
    repeat (2) @(posedge clk); #1;
    bus.m0_enable_i = 0; bus.m0_addr_i = 32'h7E0;
    wait_ack(0);

    // Tie B: round-robin favours port 1 after port 0 was granted last
    lat = 3;
    repeat (2) @(posedge clk); #1;
`ifdef MEM_ARB_RR_EN
    push(1'b1, 1'b0, 32'h200, '0, D22, 1'b0);
    push(1'b0, 1'b0, 32'h100, '0, D11, 1'b1);
`else
    push(1'b0, 1'b0, 32'h100, '0, D11, 1'b0);
    push(1'b1, 1'b0, 32'h200, '0, D22, 1'b1);
`endif
    req(0, 1'b0, 32'h100, '0);
    req(1, 1'b0, 32'h200, '0);
    fork
      begin wait_ack(0); bus.m0_enable_i = 0; end
      begin wait_ack(1); bus.m1_enable_i = 0; end
    join

    // Spurious memory ack in IDLE
    model_on = 1'b0;
    repeat (2) @(posedge clk); #1;
    bus.mem_ack_i = 1'b1; bus.mem_data_i = DA5;
    @(negedge clk);
    chk("spur_m0_ack", bus.m0_ack_o, 0);
    chk("spur_m1_ack", bus.m1_ack_o, 0);
    chk("spur_mem_enable", bus.mem_enable_o, 0);
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0;
    @(negedge clk);
    chk("spur_after_enable", bus.mem_enable_o, 0);

    // Reset asserted during BUSY1 together with a memory ack
    push(1'b1, 1'b0, 32'h400, '0, DA5, 1'b0);
    @(posedge clk); #1;
    req(1, 1'b0, 32'h400, '0);
    @(negedge clk);
    @(negedge clk);
    chk("busy1_enable", bus.mem_enable_o, 1);
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_ack_i = 1'b1; bus.m1_enable_i = 1'b0;
    @(negedge clk);
    chk("rstbusy_m1_ack", bus.m1_ack_o, 0);
    chk("rstbusy_m0_ack", bus.m0_ack_o, 0);
    @(posedge clk); #1;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
    @(negedge clk);
    chk_all_zero("rstbusy");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_enable", bus.mem_enable_o, 0);
    @(negedge clk);
    chk("post_rst_idle", bus.mem_enable_o, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
